// File: rtl/reaction_pkg.sv
// Shared types and default constants for the reaction timer.
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_RESULT  = 3'd3,
    ST_CHEAT   = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_t;

  localparam int CLKS_PER_MS_DEF = 100000;
  localparam int MAX_MS_DEF      = 9999;
  localparam int MS_W            = 14;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..CLKS_PER_MS-1 while enabled, pulses ms_tick on the last count.
module ms_tick_gen #(
  parameter int CLKS_PER_MS = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic ms_tick
);

  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLKS_PER_MS - 1);

  logic [PW-1:0] cnt;

  assign ms_tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: arms on start, times from stimulus to the first response press in ms.
//
// state      | meaning
// IDLE       | waiting for start
// ARMED      | delay generator running, waiting for stim; a press here is a cheat
// MEASURE    | stimulus seen, counting ms until a press or the ceiling
// RESULT     | valid measurement held in ms_count
// CHEAT      | pressed before stimulus, ms_count held at 0
// TIMEOUT    | ceiling reached, ms_count held at MAX_MS
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int CLKS_PER_MS = CLKS_PER_MS_DEF,
  parameter int MAX_MS      = MAX_MS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stim,
  input  logic            resp,
  output logic            delay_en,
  output logic [MS_W-1:0] ms_count,
  output logic            done,
  output logic            result_valid,
  output logic            cheat,
  output logic            timeout,
  output logic            busy
);

  localparam logic [MS_W-1:0] MS_LAST = MS_W'(MAX_MS - 1);
  localparam logic [MS_W-1:0] MS_MAX  = MS_W'(MAX_MS);

  state_t state;
  logic   resp_q;
  logic   resp_rise;
  logic   ms_tick;
  logic   measuring;

  assign resp_rise = resp & ~resp_q;
  assign measuring = (state == ST_MEASURE);

  // Prescaler sits at zero whenever not measuring, so MEASURE always starts on a fresh ms.
  ms_tick_gen #(
    .CLKS_PER_MS (CLKS_PER_MS)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (~measuring),
    .en      (measuring),
    .ms_tick (ms_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      resp_q       <= 1'b0;
      ms_count     <= '0;
      delay_en     <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      cheat        <= 1'b0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      resp_q <= resp;
      done   <= 1'b0;
      case (state)
        ST_IDLE, ST_RESULT, ST_CHEAT, ST_TIMEOUT: begin
          if (start) begin
            state        <= ST_ARMED;
            ms_count     <= '0;
            delay_en     <= 1'b1;
            busy         <= 1'b1;
            result_valid <= 1'b0;
            cheat        <= 1'b0;
            timeout      <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (resp_rise) begin
            state    <= ST_CHEAT;
            ms_count <= '0;
            delay_en <= 1'b0;
            busy     <= 1'b0;
            cheat    <= 1'b1;
            done     <= 1'b1;
          end else if (stim) begin
            state    <= ST_MEASURE;
            ms_count <= '0;
            delay_en <= 1'b0;
          end
        end
        ST_MEASURE: begin
          // A press wins over a coincident tick so the reported value is the one shown at the press.
          if (resp_rise) begin
            state        <= ST_RESULT;
            busy         <= 1'b0;
            result_valid <= 1'b1;
            done         <= 1'b1;
          end else if (ms_tick) begin
            if (ms_count == MS_LAST) begin
              state    <= ST_TIMEOUT;
              ms_count <= MS_MAX;
              busy     <= 1'b0;
              timeout  <= 1'b1;
              done     <= 1'b1;
            end else begin
              ms_count <= ms_count + 1'b1;
            end
          end
        end
        default: begin
          state        <= ST_IDLE;
          ms_count     <= '0;
          delay_en     <= 1'b0;
          busy         <= 1'b0;
          result_valid <= 1'b0;
          cheat        <= 1'b0;
          timeout      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with CLKS_PER_MS=10, MAX_MS=20.
module tb_reaction_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stim, resp;
  logic        delay_en, done, result_valid, cheat, timeout, busy;
  logic [13:0] ms_count;

  int checks = 0;
  int errors = 0;

  reaction_timer #(.CLKS_PER_MS(10), .MAX_MS(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stim         (stim),
    .resp         (resp),
    .delay_en     (delay_en),
    .ms_count     (ms_count),
    .done         (done),
    .result_valid (result_valid),
    .cheat        (cheat),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // flags order: delay_en, done, result_valid, cheat, timeout, busy
  typedef struct {
    logic        start;
    logic        stim;
    logic        resp;
    logic [5:0]  flags;
    logic [13:0] ms;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [5:0] flags_now();
    return {delay_en, done, result_valid, cheat, timeout, busy};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Arms, raises stim and returns just after the edge that enters MEASURE.
  task automatic arm_and_measure();
    pulse_start();
    chk("armed_flags", int'(flags_now()), 6'b100001);
    repeat (4) cyc();
    stim = 1'b1;
    cyc();
    chk("measure_entry_flags", int'(flags_now()), 6'b000001);
    chk("measure_entry_ms", int'(ms_count), 0);
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; stim = 1'b0; resp = 1'b0;
    #12;
    chk("reset_flags", int'(flags_now()), 0);
    chk("reset_ms", int'(ms_count), 0);
    @(negedge clk);
    rst = 1'b0;
    #3;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 6'b000000, 14'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 6'b100001, 14'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 6'b010100, 14'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 6'b000100, 14'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 6'b000100, 14'd0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 6'b100001, 14'd0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 6'b010100, 14'd0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 6'b000100, 14'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 6'b000100, 14'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 6'b100001, 14'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 6'b000001, 14'd0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 6'b000001, 14'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 6'b011000, 14'd0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 6'b001000, 14'd0};

    for (int i = 0; i < 14; i++) begin
      start = vecs[i].start;
      stim  = vecs[i].stim;
      resp  = vecs[i].resp;
      cyc();
      chk($sformatf("vec%0d_flags", i), int'(flags_now()), int'(vecs[i].flags));
      chk($sformatf("vec%0d_ms", i), int'(ms_count), int'(vecs[i].ms));
    end
    start = 1'b0; stim = 1'b0; resp = 1'b0;
    repeat (2) cyc();

    // press 37 cycles into MEASURE -> 3 ms
    arm_and_measure();
    dones = 0;
    for (int k = 1; k <= 37; k++) begin
      cyc();
      if (done) dones++;
      if (k == 9)  chk("ms_before_first_tick", int'(ms_count), 0);
      if (k == 10) chk("ms_after_first_tick", int'(ms_count), 1);
      if (k == 20) stim = 1'b0;
    end
    chk("no_early_done", dones, 0);
    chk("stim_fall_ignored_busy", int'(busy), 1);
    resp = 1'b1;
    cyc();
    chk("result_flags", int'(flags_now()), 6'b011000);
    chk("result_ms", int'(ms_count), 3);
    cyc();
    chk("result_hold_flags", int'(flags_now()), 6'b001000);
    chk("result_hold_ms", int'(ms_count), 3);
    resp = 1'b0;
    stim = 1'b0;
    repeat (2) cyc();

    // press coinciding with a tick freezes the pre-tick value
    arm_and_measure();
    repeat (39) cyc();
    resp = 1'b1;
    cyc();
    chk("tick_coincide_flags", int'(flags_now()), 6'b011000);
    chk("tick_coincide_ms", int'(ms_count), 3);
    resp = 1'b0;
    stim = 1'b0;
    repeat (2) cyc();

    // timeout at 200 cycles
    arm_and_measure();
    dones = 0;
    for (int k = 1; k <= 199; k++) begin
      cyc();
      if (done || timeout) dones++;
    end
    chk("pre_timeout_events", dones, 0);
    chk("pre_timeout_ms", int'(ms_count), 19);
    cyc();
    chk("timeout_flags", int'(flags_now()), 6'b010010);
    chk("timeout_ms", int'(ms_count), 20);
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (done) dones++;
    end
    chk("timeout_single_done", dones, 0);
    chk("timeout_hold_flags", int'(flags_now()), 6'b000010);
    chk("timeout_saturated_ms", int'(ms_count), 20);
    stim = 1'b0;
    repeat (2) cyc();

    // reset mid-measurement, start pulses while measuring ignored
    arm_and_measure();
    for (int k = 1; k <= 70; k++) begin
      start = (k == 25 || k == 40) ? 1'b1 : 1'b0;
      cyc();
    end
    start = 1'b0;
    chk("mid_measure_busy", int'(flags_now()), 6'b000001);
    chk("mid_measure_ms", int'(ms_count), 7);
    rst = 1'b1;
    #1;
    chk("async_reset_flags", int'(flags_now()), 0);
    chk("async_reset_ms", int'(ms_count), 0);
    cyc();
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (done || busy || ms_count != 0) dones++;
    end
    chk("post_reset_quiet", dones, 0);
    stim = 1'b0;
    cyc();
    pulse_start();
    chk("post_reset_arm", int'(flags_now()), 6'b100001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
